// File: rtl/aes_link_pkg.sv
// Shared definitions for the AES chip link scheduler: FSM states, transfer sizes
// and a saturating counter helper.
package aes_link_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int TX_BYTES    = 32;

  typedef enum logic [2:0] {
    IDLE,
    SEND_KEY,
    SEND_PT,
    WAIT_RX,
    CHECK
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/aes_link_rxsync.sv
// Brings the chip's result strobe and byte into the clk domain through two-flop
// synchronizers and flags each rising edge of the synchronized strobe.
module aes_link_rxsync (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_i,
  input  logic       rx_stb_i,
  output logic [7:0] data_o,
  output logic       stb_rise_o
);

  logic [1:0] stb_sync_q;
  logic       stb_prev_q;
  logic [7:0] data_meta_q;
  logic [7:0] data_sync_q;

  // The chip holds the byte steady before raising sho, so the bus shares the strobe's latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_sync_q  <= '0;
      stb_prev_q  <= 1'b0;
      data_meta_q <= '0;
      data_sync_q <= '0;
    end else begin
      stb_sync_q  <= {stb_sync_q[0], rx_stb_i};
      stb_prev_q  <= stb_sync_q[1];
      data_meta_q <= rx_data_i;
      data_sync_q <= data_meta_q;
    end
  end

  assign data_o     = data_sync_q;
  assign stb_rise_o = stb_sync_q[1] & ~stb_prev_q;

endmodule

// File: rtl/aes_link_sched.sv
// Streams key then plaintext to an AES chip, collects the 16-byte result and scores it.
// Define AES_LINK_CMP_EN to enable expected-ciphertext comparison, pass and correct.
module aes_link_sched
  import aes_link_pkg::*;
#(
  parameter int BYTE_DIV   = 250,
  parameter int RX_TIMEOUT = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] ptext_i,
  input  logic [127:0] expect_i,
  output logic [7:0]   tx_data_o,
  output logic         tx_stb_o,
  input  logic [7:0]   rx_data_i,
  input  logic         rx_stb_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         pass_o,
  output logic         timeout_o,
  output logic [31:0]  total_o,
  output logic [31:0]  correct_o
);

  state_e       state_q, state_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic         tx_stb_q, tx_stb_d;
  logic [255:0] tx_shift_q, tx_shift_d;
  logic [31:0]  div_q, div_d;
  logic [5:0]   byte_q, byte_d;
  logic [31:0]  to_q, to_d;
  logic [4:0]   rx_cnt_q, rx_cnt_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;
  logic         timeout_q, timeout_d;
  logic [31:0]  total_q, total_d;
  logic [31:0]  correct_q, correct_d;
  logic [7:0]   rx_byte;
  logic         rx_rise;

`ifdef AES_LINK_CMP_EN
  logic [127:0] exp_q, exp_d;
  logic [127:0] result_q, result_d;
`else
  logic unused_cmp;
  assign unused_cmp = ^{expect_i, rx_byte};
`endif

  aes_link_rxsync u_rxsync (
    .clk       (clk),
    .rst       (rst),
    .rx_data_i (rx_data_i),
    .rx_stb_i  (rx_stb_i),
    .data_o    (rx_byte),
    .stb_rise_o(rx_rise)
  );

  // NOTE: every _d is defaulted first so this block never infers a latch.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_stb_d   = 1'b0;
    tx_shift_d = tx_shift_q;
    div_d      = div_q;
    byte_d     = byte_q;
    to_d       = to_q;
    rx_cnt_d   = rx_cnt_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    total_d    = total_q;
    correct_d  = correct_q;
`ifdef AES_LINK_CMP_EN
    exp_d      = exp_q;
    result_d   = result_q;
`endif
    unique case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse is deliberately dropped.
        if (start_i && !done_q) begin
          state_d    = SEND_KEY;
          tx_stb_d   = 1'b1;
          tx_data_d  = key_i[127:120];
          tx_shift_d = {key_i[119:0], ptext_i, 8'h00};
          div_d      = '0;
          byte_d     = 6'd1;
`ifdef AES_LINK_CMP_EN
          exp_d      = expect_i;
`endif
        end
      end
      SEND_KEY, SEND_PT: begin
        if (tx_stb_q && byte_q == 6'(TX_BYTES)) begin
          state_d  = WAIT_RX;
          to_d     = '0;
          rx_cnt_d = '0;
        end else if (div_q == 32'(BYTE_DIV - 1)) begin
          div_d      = '0;
          tx_stb_d   = 1'b1;
          tx_data_d  = tx_shift_q[255:248];
          tx_shift_d = {tx_shift_q[247:0], 8'h00};
          byte_d     = byte_q + 6'd1;
          if (byte_q == 6'(BLOCK_BYTES)) state_d = SEND_PT;
        end else begin
          div_d = div_q + 32'd1;
        end
      end
      WAIT_RX: begin
        if (rx_rise) begin
          to_d     = '0;
          rx_cnt_d = rx_cnt_q + 5'd1;
`ifdef AES_LINK_CMP_EN
          result_d = {result_q[119:0], rx_byte};
`endif
          if (rx_cnt_q == 5'(BLOCK_BYTES - 1)) state_d = CHECK;
        end else if (to_q == 32'(RX_TIMEOUT - 1)) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
          total_d   = sat_inc(total_q);
        end else begin
          to_d = to_q + 32'd1;
        end
      end
      CHECK: begin
        state_d   = IDLE;
        done_d    = 1'b1;
        timeout_d = 1'b0;
        total_d   = sat_inc(total_q);
`ifdef AES_LINK_CMP_EN
        pass_d    = (result_q == exp_q);
        if (result_q == exp_q) correct_d = sat_inc(correct_q);
`else
        pass_d    = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_stb_q   <= 1'b0;
      tx_shift_q <= '0;
      div_q      <= '0;
      byte_q     <= '0;
      to_q       <= '0;
      rx_cnt_q   <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      total_q    <= '0;
      correct_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_stb_q   <= tx_stb_d;
      tx_shift_q <= tx_shift_d;
      div_q      <= div_d;
      byte_q     <= byte_d;
      to_q       <= to_d;
      rx_cnt_q   <= rx_cnt_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      total_q    <= total_d;
      correct_q  <= correct_d;
    end
  end

`ifdef AES_LINK_CMP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q    <= '0;
      result_q <= '0;
    end else begin
      exp_q    <= exp_d;
      result_q <= result_d;
    end
  end
  assign correct_o = correct_q;
`else
  assign correct_o = '0;
`endif

  assign tx_data_o = tx_data_q;
  assign tx_stb_o  = tx_stb_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign timeout_o = timeout_q;
  assign total_o   = total_q;

endmodule

// File: tb/tb_aes_link_sched.sv
// Self-checking bench for aes_link_sched: directed AES vectors, timeout, reset abort,
// held start, then randomized transactions scored by a transaction-level model.
module tb_aes_link_sched;
  import aes_link_pkg::*;

  localparam int BYTE_DIV   = 4;
  localparam int RX_TIMEOUT = 1000;
`ifdef AES_LINK_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  localparam logic [127:0] K_VEC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_VEC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_VEC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_BAD = 128'h69c4e0d86a7b0430d8cdb78070b4c55b;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0, ptext = '0, exp_in = '0;
  logic [7:0]   tx_data;
  logic         tx_stb;
  logic [7:0]   rx_data = '0;
  logic         rx_stb = 1'b0;
  logic         busy, done, pass, timeout;
  logic [31:0]  total, correct;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int m_total = 0;
  int m_correct = 0;
  int long_pulses = 0;
  logic prev_done = 1'b0;

  typedef struct {
    int          c;
    logic        pass;
    logic        tmo;
    logic [31:0] total;
    logic [31:0] correct;
    logic        busy;
  } done_s;
  done_s done_log[$];

  aes_link_sched #(.BYTE_DIV(BYTE_DIV), .RX_TIMEOUT(RX_TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .key_i    (key),
    .ptext_i  (ptext),
    .expect_i (exp_in),
    .tx_data_o(tx_data),
    .tx_stb_o (tx_stb),
    .rx_data_i(rx_data),
    .rx_stb_i (rx_stb),
    .busy_o   (busy),
    .done_o   (done),
    .pass_o   (pass),
    .timeout_o(timeout),
    .total_o  (total),
    .correct_o(correct)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Snapshot every done pulse just after the edge that raises it.
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (prev_done) long_pulses++;
      done_log.push_back('{c: cyc, pass: pass, tmo: timeout, total: total,
                           correct: correct, busy: busy});
    end
    prev_done = done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic drive_start(input logic [127:0] k, p, e, output int s);
    @(negedge clk);
    key = k; ptext = p; exp_in = e; start = 1'b1;
    s = cyc;
  endtask

  // Expect strobe i at cycle s+1+BYTE_DIV*i carrying byte i of {key, ptext}.
  task automatic collect_tx(input int s, input logic [127:0] k, p, input bit hold,
                            input int stop_after, output int last_cyc);
    logic [255:0] stream;
    logic [7:0]   last_b;
    int n, hold_err, budget;
    stream = {k, p};
    n = 0; hold_err = 0; last_b = '0; last_cyc = -1;
    budget = TX_BYTES * BYTE_DIV + 20;
    while (n < stop_after && budget > 0) begin
      @(negedge clk);
      budget--;
      if (tx_stb) begin
        check("tx_cycle", 128'(cyc), 128'(s + 1 + BYTE_DIV * n));
        check("tx_byte", 128'(tx_data), 128'(stream[255 - 8*n -: 8]));
        last_b = tx_data; last_cyc = cyc; n++;
        if (!hold) start = 1'b0;
      end else if (n > 0 && tx_data !== last_b) begin
        hold_err++;
      end
      if (n == 3) begin rx_data = 8'($urandom); rx_stb = 1'b1; end
      if (n == 5) rx_stb = 1'b0;
    end
    check("tx_count", 128'(n), 128'(stop_after));
    check("tx_hold", 128'(hold_err), 128'(0));
  endtask

  task automatic send_reply(input logic [127:0] r, input int pre_gap, input int mid_gap);
    repeat (pre_gap) @(negedge clk);
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rx_data = r[127 - 8*i -: 8];
      repeat (2) @(negedge clk);
      rx_stb = 1'b1;
      repeat ($urandom_range(2, 3)) @(negedge clk);
      rx_stb = 1'b0;
      if (i == 7) repeat (mid_gap) @(negedge clk);
    end
  endtask

  task automatic check_done(input int budget, input bit exp_pass, input bit exp_tmo,
                            output int d_cyc);
    done_s snap;
    d_cyc = -1;
    while (done_log.size() == 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (done_log.size() == 0) begin
      check("done_wait", 128'(0), 128'(1));
    end else begin
      snap = done_log.pop_front();
      d_cyc = snap.c;
      m_total++;
      if (exp_pass) m_correct++;
      check("pass", 128'(snap.pass), 128'(exp_pass));
      check("timeout", 128'(snap.tmo), 128'(exp_tmo));
      check("total", 128'(snap.total), 128'(m_total));
      check("correct", 128'(snap.correct), 128'(m_correct));
      check("busy_at_done", 128'(snap.busy), 128'(0));
    end
  endtask

  task automatic run_txn(input logic [127:0] k, p, e, r, input bit silent,
                         input int pre_gap, input int mid_gap);
    int s, l, d;
    drive_start(k, p, e, s);
    collect_tx(s, k, p, 1'b0, TX_BYTES, l);
    if (silent) begin
      check_done(RX_TIMEOUT + 50, 1'b0, 1'b1, d);
      check("timeout_cycle", 128'(d), 128'(l + 1 + RX_TIMEOUT));
    end else begin
      send_reply(r, pre_gap, mid_gap);
      check_done(50, CMP_EN && (r == e), 1'b0, d);
    end
  endtask

  initial begin
    int s, l, d;
    logic [127:0] k, p, e, r;
    int idx;

    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_tx_stb", 128'(tx_stb), 128'(0));
    check("rst_tx_data", 128'(tx_data), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_total", 128'(total), 128'(0));
    check("rst_correct", 128'(correct), 128'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Abort after the 10th byte: everything returns to zero at once.
    drive_start(K_VEC, P_VEC, C_VEC, s);
    collect_tx(s, K_VEC, P_VEC, 1'b0, 10, l);
    rst = 1'b1;
    #1;
    check("abort_tx_stb", 128'(tx_stb), 128'(0));
    check("abort_tx_data", 128'(tx_data), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_flags", 128'({done, pass, timeout}), 128'(0));
    check("abort_total", 128'(total), 128'(0));
    check("abort_correct", 128'(correct), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_idle", 128'({busy, tx_stb}), 128'(0));

    // Known AES vector with start held high; the repeat start is taken only after done.
    drive_start(K_VEC, P_VEC, C_VEC, s);
    collect_tx(s, K_VEC, P_VEC, 1'b1, TX_BYTES, l);
    send_reply(C_VEC, 0, 0);
    check_done(50, CMP_EN, 1'b0, d);
    collect_tx(d + 1, K_VEC, P_VEC, 1'b0, TX_BYTES, l);
    send_reply(C_BAD, 0, 0);
    check_done(50, 1'b0, 1'b0, d);

    // Silent chip, then a reply whose total span exceeds the timeout but no single gap does.
    run_txn(K_VEC, P_VEC, C_VEC, '0, 1'b1, 0, 0);
    run_txn(K_VEC, P_VEC, C_VEC, C_VEC, 1'b0, 500, 700);

    for (int t = 0; t < 4; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      e = {$urandom, $urandom, $urandom, $urandom};
      r = e;
      if ($urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, 15);
        r[idx*8 +: 8] = r[idx*8 +: 8] ^ 8'($urandom_range(1, 255));
      end
      run_txn(k, p, e, r, 1'b0, $urandom_range(0, 20), $urandom_range(0, 20));
    end

    repeat (10) @(negedge clk);
    check("done_pulse_width", 128'(long_pulses), 128'(0));
    check("done_extra", 128'(done_log.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_link_sched.md
AES_LINK_SCHED -- requirements
Module: aes_link_sched

Interface
REQ-001 SHALL have parameter BYTE_DIV, default 250, clk cycles between successive transmitted bytes (legal minimum 2).
REQ-002 SHALL have parameter RX_TIMEOUT, default 100000, clk cycles allowed without a received byte before a transfer is abandoned.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request one encryption transaction; sampled only in IDLE.
REQ-006 SHALL have port key  input  128  cipher key, captured on accepted start.
REQ-007 SHALL have port ptext  input  128  plaintext, captured on accepted start.
REQ-008 SHALL have port expect  input  128  expected ciphertext, captured on accepted start.
REQ-009 SHALL have port tx_data  output  8  byte to chip user_data.
REQ-010 SHALL have port tx_stb  output  1  one-cycle byte strobe to chip shi.
REQ-011 SHALL have port rx_data  input  8  chip result byte, asynchronous to clk.
REQ-012 SHALL have port rx_stb  input  1  chip result strobe (sho), asynchronous to clk.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-015 SHALL have port pass  output  1  result of last transaction, valid from done until next done.
REQ-016 SHALL have port timeout  output  1  last transaction ended by timeout, valid from done until next done.
REQ-017 SHALL have ports total and correct  output  32 each  transaction and match counters.

Function
REQ-018 SHALL implement states IDLE, SEND_KEY, SEND_PT, WAIT_RX, CHECK.
REQ-019 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-020 SHALL pulse tx_stb first in the cycle after an accepted start, then every BYTE_DIV cycles, 32 pulses total.
REQ-021 SHALL send key bytes [127:120] first down to [7:0] (SEND_KEY), then ptext in the same order (SEND_PT); tx_data SHALL hold each byte until the next strobe.
REQ-022 SHALL enter WAIT_RX the cycle after the 32nd strobe, with the timeout counter cleared.
REQ-023 SHALL pass rx_stb and rx_data through two-flop synchronizers and capture the synchronized rx_data on each synchronized rx_stb rising edge, shifting it into result[7:0] (first byte becomes result[127:120]).
REQ-024 SHALL ignore rx_stb edges outside WAIT_RX.
REQ-025 SHALL clear the timeout counter on every captured byte and enter CHECK the cycle after the 16th capture.
REQ-026 SHALL, in CHECK, pulse done, set pass = (result == expect), clear timeout, increment total, increment correct if pass, then return to IDLE.
REQ-027 SHALL, if the timeout counter reaches RX_TIMEOUT in WAIT_RX, pulse done, set timeout=1 and pass=0, increment total only, and return to IDLE.
REQ-028 SHALL saturate total and correct at 32'hFFFF_FFFF.
REQ-029 SHALL allow a start in the cycle done is high to be ignored; start is accepted from the following IDLE cycle.

Reset
REQ-030 SHALL on rst force IDLE, tx_data=0, tx_stb=0, busy=0, done=0, pass=0, timeout=0, total=0, correct=0, synchronizers and counters to 0.
REQ-031 SHALL abandon any transaction on rst mid-operation without counting it.

Configuration
REQ-032 SHALL, with AES_LINK_CMP_EN defined, implement expect capture, comparison, pass and correct as above.
REQ-033 SHALL, without AES_LINK_CMP_EN, ignore expect, tie pass and correct to 0, and still count total.

Structure
REQ-034 SHALL place the state enum, BLOCK_BYTES=16 and TX_BYTES=32 in shared package aes_link_pkg.
REQ-035 SHALL implement synchronization and edge detection in sub-module aes_link_rxsync.

Verification
REQ-036 SHALL cover: key 000102..0f, ptext 00112233..eeff, expect 69c4e0d86a7b0430d8cdb78070b4c55a, model returns that ciphertext -> done, pass=1, total=1, correct=1.
REQ-037 SHALL cover: same stimulus, model corrupts last byte to 5b -> pass=0, total=2, correct=1.
REQ-038 SHALL cover: model silent after 32 bytes, RX_TIMEOUT=1000 -> done exactly 1000 cycles after WAIT_RX entry, timeout=1, total increments.
REQ-039 SHALL cover: BYTE_DIV=4, start held high throughout -> strobes at cycles 1,5,...,125; second start honoured only after done.
REQ-040 SHALL cover: rst asserted after 10th tx byte -> all outputs 0 immediately, counters unchanged at 0, next transaction completes normally.
